// File: rtl/simd_alu_pipe_if.sv
// Handshaked operand/result bundle for simd_alu_pipe.
// master drives operands and out_ready; slave is the ALU pipeline.
interface simd_alu_pipe_if #(
  parameter int LANES = 4,
  parameter int LW    = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*LW-1:0]     a;
  logic [LANES*LW-1:0]     b;
  logic [LANES-1:0]        cin;
  logic [4*LANES-1:0]      opcode;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*LANES*LW-1:0]   out;
  logic [LANES-1:0]        carry;

  modport master (
    output in_valid, a, b, cin, opcode, out_ready,
    input  in_ready, out_valid, out, carry
  );

  modport slave (
    input  in_valid, a, b, cin, opcode, out_ready,
    output in_ready, out_valid, out, carry
  );
endinterface

// File: rtl/simd_alu_pipe.sv
// Two-stage SIMD ALU: S1 captures operands, S2 computes and holds per-lane results.
// Both stages stall independently so a full pipe holds two bundles under backpressure.
module simd_alu_pipe #(
  parameter int LANES = 4,
  parameter int LW    = 8
) (
  input logic           clk,
  input logic           reset,
  simd_alu_pipe_if.slave bus
);
  localparam int SW = $clog2(LW);

  logic                  s1_valid_q;
  logic [LANES*LW-1:0]   a_q;
  logic [LANES*LW-1:0]   b_q;
  logic [LANES-1:0]      cin_q;
  logic [4*LANES-1:0]    op_q;

  logic                  s2_valid_q;
  logic [2*LANES*LW-1:0] out_q;
  logic [2*LANES*LW-1:0] out_d;
  logic [LANES-1:0]      carry_q;
  logic [LANES-1:0]      carry_d;

  logic s1_adv;
  logic s2_adv;

  assign s2_adv       = !s2_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LW-1:0]   la;
    logic [LW-1:0]   lb;
    logic            lc;
    logic [3:0]      lop;
    logic [SW-1:0]   sh;
    logic [LW:0]     sum;
    logic [LW:0]     dif;
    logic [LW:0]     shl_w;
    logic [LW:0]     shr_w;
    logic [LW-1:0]   rol_w;
    logic [2*LW-1:0] r;
    logic            c;

    assign la  = a_q[i*LW +: LW];
    assign lb  = b_q[i*LW +: LW];
    assign lc  = cin_q[i];
    assign lop = op_q[4*i +: 4];
    assign sh  = lb[SW-1:0];

    assign sum   = {1'b0, la} + {1'b0, lb} + {{LW{1'b0}}, lc};
    assign dif   = {1'b0, la} - {1'b0, lb} - {{LW{1'b0}}, lc};
    // One guard bit catches the last bit shifted out on either side
    assign shl_w = {1'b0, la} << sh;
    assign shr_w = {la, 1'b0} >> sh;
    assign rol_w = (la << sh) | (la >> (LW - int'(sh)));

    always_comb begin
      r = '0;
      c = 1'b0;
      case (lop)
        4'h0: begin r = {{LW{1'b0}}, sum[LW-1:0]}; c = sum[LW]; end
        4'h1: begin r = {{LW{1'b0}}, dif[LW-1:0]}; c = dif[LW]; end
        4'h2: r = {{LW{1'b0}}, la} * {{LW{1'b0}}, lb};
        4'h3: r = {{LW{1'b0}}, la & lb};
        4'h4: r = {{LW{1'b0}}, la | lb};
        4'h5: r = {{LW{1'b0}}, la ^ lb};
        4'h6: r = {{LW{1'b0}}, ~la};
        4'h7: begin r = {{LW{1'b0}}, shl_w[LW-1:0]}; c = shl_w[LW]; end
        4'h8: begin r = {{LW{1'b0}}, shr_w[LW:1]}; c = shr_w[0]; end
        4'h9: r = {{LW{1'b0}}, rol_w};
        4'hA: begin r = {{(2*LW-1){1'b0}}, la < lb}; c = (la == lb); end
        4'hB: begin r = {{LW{1'b0}}, (la > lb) ? la : lb}; c = (la == lb); end
        4'hC: begin r = {{LW{1'b0}}, (la < lb) ? la : lb}; c = (la == lb); end
        4'hD: begin
          r = {{LW{1'b0}}, sum[LW] ? {LW{1'b1}} : sum[LW-1:0]};
          c = sum[LW];
        end
        4'hE: r = {{LW{1'b0}}, la};
        default: ;
      endcase
    end

    assign out_d[i*2*LW +: 2*LW] = r;
    assign carry_d[i]            = c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= '0;
      op_q       <= '0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      carry_q    <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          a_q   <= bus.a;
          b_q   <= bus.b;
          cin_q <= bus.cin;
          op_q  <= bus.opcode;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_q   <= out_d;
          carry_q <= carry_d;
        end
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out       = out_q;
  assign bus.carry     = carry_q;
endmodule

// File: tb/tb_simd_alu_pipe.sv
// Self-checking bench for simd_alu_pipe: directed literal cases plus randomized
// traffic scored against an arithmetic per-lane model.
module tb_simd_alu_pipe;
  localparam int LANES = 4;
  localparam int LW    = 8;
  localparam int DW    = LANES * LW;
  localparam int OW    = 2 * LANES * LW;

  typedef longint unsigned u64_t;
  typedef struct packed {
    logic [OW-1:0]    o;
    logic [LANES-1:0] c;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  simd_alu_pipe_if #(.LANES(LANES), .LW(LW)) bus ();
  simd_alu_pipe #(.LANES(LANES), .LW(LW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  res_t exp_q[$];
  res_t e;
  logic hold_prev = 1'b0;
  logic [OW-1:0]    prev_out;
  logic [LANES-1:0] prev_carry;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference lane: plain unsigned arithmetic on 64-bit integers.
  function automatic void ref_lane(input int op, input u64_t a, input u64_t b, input u64_t ci,
                                   output u64_t r, output bit c);
    u64_t m = u64_t'(1) << LW;
    int   sh = int'(b % LW);
    u64_t s;
    r = 0;
    c = 0;
    case (op)
      0:  begin s = a + b + ci; c = (s >= m); r = s % m; end
      1:  begin c = (a < b + ci); r = (a + 2*m - b - ci) % m; end
      2:  r = a * b;
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = (m - 1) - a;
      7:  begin r = (a << sh) % m; c = (sh != 0) && (((a >> (LW - sh)) & 1) != 0); end
      8:  begin r = a >> sh; c = (sh != 0) && (((a >> (sh - 1)) & 1) != 0); end
      9:  r = (sh == 0) ? a : (((a << sh) % m) | (a >> (LW - sh)));
      10: begin r = (a < b) ? 1 : 0; c = (a == b); end
      11: begin r = (a > b) ? a : b; c = (a == b); end
      12: begin r = (a < b) ? a : b; c = (a == b); end
      13: begin s = a + b + ci; c = (s > m - 1); r = c ? m - 1 : s; end
      14: r = a;
      default: r = 0;
    endcase
  endfunction

  function automatic res_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [LANES-1:0] ci, input logic [4*LANES-1:0] op);
    res_t res;
    u64_t r;
    bit   c;
    res.o = '0;
    res.c = '0;
    for (int i = 0; i < LANES; i++) begin
      ref_lane(int'(op[4*i +: 4]), u64_t'(a[i*LW +: LW]), u64_t'(b[i*LW +: LW]),
               u64_t'(ci[i]), r, c);
      res.o[i*2*LW +: 2*LW] = r[2*LW-1:0];
      res.c[i] = c;
    end
    return res;
  endfunction

  function automatic logic [DW-1:0] rvec();
    logic [DW-1:0] v;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 3))
        0:       v[i*LW +: LW] = '0;
        1:       v[i*LW +: LW] = '1;
        default: v[i*LW +: LW] = LW'($urandom);
      endcase
    end
    return v;
  endfunction

  // Scoreboard and hold-stability checker, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_out", bus.out, prev_out);
        chk("hold_carry", bus.carry, prev_carry);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got out %0h with no bundle outstanding", bus.out);
        end else begin
          e = exp_q.pop_front();
          chk("sb_out", bus.out, e.o);
          chk("sb_carry", bus.carry, e.c);
          n_out++;
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.opcode));
      hold_prev  = bus.out_valid && !bus.out_ready;
      prev_out   = bus.out;
      prev_carry = bus.carry;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [LANES-1:0] ci, input logic [4*LANES-1:0] op);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.cin = ci;
    bus.opcode = op;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 for 50 cycles expected 1");
    end
  endtask

  task automatic wait_out(input logic [OW-1:0] exp_o, input logic [LANES-1:0] exp_c,
                          input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    if (seen) begin
      chk({name, "_out"}, bus.out, exp_o);
      chk({name, "_carry"}, bus.carry, exp_c);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got out_valid 0 for 20 cycles expected 1", name);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = '0;
    bus.opcode = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out", bus.out, 0);
    chk("rst_carry", bus.carry, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rel_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;

    // ADD with latency check
    send(32'hff569bac, 32'haa478df1, 4'h0, 16'h0000);
    @(negedge clk);
    chk("lat_cyc1_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_cyc2_valid", bus.out_valid, 1);
    chk("add_out", bus.out, 64'h00a9_009d_0028_009d);
    chk("add_carry", bus.carry, 4'b1011);
    @(posedge clk);
    #1;

    send(32'hff569bac, 32'haa478df1, 4'h0, 16'h2222);
    wait_out(64'ha956_17da_555f_a1ec, 4'b0000, "mul");
    send(32'hff569bac, 32'haa478df1, 4'h0, 16'hDDDD);
    wait_out(64'h00ff_009d_00ff_00ff, 4'b1011, "adds");
    send(32'hff569bac, 32'haa478df1, 4'b0001, 16'h1111);
    wait_out(64'h0055_000f_000e_00ba, 4'b0001, "sub");
    send(32'h0000_0081, 32'h0000_0003, 4'h0, 16'hF7A9);
    wait_out(64'h0000_0000_0000_000c, 4'b0010, "mixed");

    // Back-to-back with a willing consumer never stalls
    for (int k = 0; k < 6; k++) begin
      bus.in_valid = 1'b1;
      bus.a = rvec();
      bus.b = rvec();
      bus.cin = LANES'($urandom);
      bus.opcode = (4*LANES)'($urandom);
      @(negedge clk);
      chk("tput_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: two bundles fill the pipe, the rest wait
    bus.out_ready = 1'b0;
    send(rvec(), rvec(), LANES'($urandom), (4*LANES)'($urandom));
    send(rvec(), rvec(), LANES'($urandom), (4*LANES)'($urandom));
    bus.in_valid = 1'b1;
    bus.a = rvec();
    bus.b = rvec();
    bus.cin = LANES'($urandom);
    bus.opcode = 16'h7823;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      @(posedge clk);
      #1;
    end
    n0 = n_out;
    bus.out_ready = 1'b1;
    send(bus.a, bus.b, bus.cin, bus.opcode);
    send(rvec(), rvec(), LANES'($urandom), (4*LANES)'($urandom));
    repeat (6) @(posedge clk);
    #1;
    chk("bp_out_count", n_out - n0, 4);

    // Asynchronous reset with both stages occupied
    bus.out_ready = 1'b0;
    send(rvec(), rvec(), LANES'($urandom), (4*LANES)'($urandom));
    send(rvec(), rvec(), LANES'($urandom), (4*LANES)'($urandom));
    chk("arst_pre_valid", bus.out_valid, 1);
    chk("arst_pre_in_ready", bus.in_ready, 0);
    reset = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out", bus.out, 0);
    chk("arst_carry", bus.carry, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("arst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("arst_no_stale", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random consumer stalls
    repeat (1500) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.a = rvec();
      bus.b = rvec();
      bus.cin = LANES'($urandom);
      bus.opcode = (4*LANES)'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/simd_alu_pipe.md
Name: simd_alu_pipe

Overview:
- Parametrised, pipelined successor to the fixed 4-lane x 8-bit SIMD_ALU.
- Operands are split into LANES independent lanes of LW bits, each with its own 4-bit opcode and carry-in.
- Each lane produces a 2*LW-bit result field plus a carry/flag bit.
- Adds a valid/ready handshake on input and output, a 2-stage pipeline with full backpressure, unsigned multiply and saturating add.

Parameters:
- LANES, 4, number of SIMD lanes (>=1).
- LW, 8, lane width in bits (power of 2, >=4).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- a  in  LANES*LW  operand A; lane i = a[i*LW +: LW].
- b  in  LANES*LW  operand B; same lane slicing.
- cin  in  LANES  per-lane carry/borrow in.
- opcode  in  4*LANES  per-lane opcode; lane i = opcode[4*i +: 4].
- out_valid  out  1  result bundle valid.
- out_ready  in  1  consumer accepts the result.
- out  out  2*LANES*LW  per-lane result; lane i = out[i*2*LW +: 2*LW].
- carry  out  LANES  per-lane carry/flag.

Behaviour:
- Reset (reset=0, asynchronous): both stage valids cleared, out=0, carry=0, out_valid=0. Any in-flight bundle is discarded. in_ready=1 from the first cycle after release.
- Handshake: an input transfer occurs when in_valid&&in_ready; an output transfer occurs when out_valid&&out_ready.
- Once out_valid is high, out, carry and out_valid are held stable until out_ready is asserted.
- Pipeline stages:
  - S1 registers a, b, cin and opcode.
  - S2 computes and registers out/carry.
  - Latency: exactly 2 cycles from the accept edge to out_valid, with no stalls.
  - Throughput: 1 bundle per cycle.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational; no combinational path from in_valid).
- Simultaneous output transfer and new input in the same cycle: no bubble inserted.
- With out_ready low, at most 2 bundles are held. in_ready drops only when both stages are full.
- Per-lane ops (A, B = lane operands, R = 2*LW-bit result, C = carry bit; unsigned unless stated). Upper LW bits of R are 0 except for MUL.
  - 0 ADD: R = A+B+cin; C = carry out.
  - 1 SUB: R = A-B-cin, mod 2^LW; C = 1 on borrow.
  - 2 MUL: R = A*B, full 2*LW bits; C = 0.
  - 3 AND, 4 OR, 5 XOR: bitwise; C = 0.
  - 6 NOT: R = ~A; C = 0.
  - 7 SHL: R = A << B[log2(LW)-1:0]; C = last bit shifted out (0 if shift amount is 0).
  - 8 SHR (logical): same rules as SHL for C.
  - 9 ROL: R = A rotated left by B[log2(LW)-1:0]; C = 0.
  - A CMP: R = (A<B); C = (A==B).
  - B MAX, C MIN: C = (A==B).
  - D ADDS (saturating): R = min(A+B+cin, 2^LW-1); C = 1 if saturated.
  - E PASS: R = A; C = 0.
  - F NOP: R = 0; C = 0.
- Lanes are fully independent: no carry propagates across lanes, and a lane's cin only affects opcodes 0, 1 and D.

Test Plan:
- Reset release, then a=ff569bac, b=aa478df1, cin=0, opcode=0000 (all ADD) -> out_valid 2 cycles after accept; out=00a9_009d_0028_009d, carry=4'b1011.
- Same operands, opcode=2222 (all MUL) -> out=a956_17da_555f_a1ec, carry=0000.
- Same operands, opcode=DDDD (ADDS) -> out=00ff_009d_00ff_00ff, carry=1011. Then opcode=1111 (SUB), cin=4'b0001 -> lane0 (ac-f1-1) R=00ba, C=1; lane3 (ff-aa) R=0055, C=0.
- Backpressure: stream 4 back-to-back bundles with out_ready=0 -> in_ready drops after 2 accepts and out/carry hold stable. Raise out_ready -> all 4 results emerge in order, one per cycle, none lost or duplicated.
- Assert reset for 1 cycle while both stages are valid -> out_valid=0, out=0, carry=0 immediately (asynchronously). No stale result appears after release.
- Mixed opcode=F7A9, a=0000_0081, b=0000_0003 -> lane0 ROL 81 by 3 gives R=000c; lane1 CMP 00 vs 00 gives R=0000, C=1; lane2 SHL 00 gives R=0, C=0; lane3 NOP gives R=0, C=0.
